sp_result_writer: RTL and testbench

- Upstream neighbour of the output stage. Accepts the compute datapath's result stream through a valid/ready handshake.
- Writes each result into the scratchpad SRAM (sram_1R1W) through that SRAM's write port: WE, WriteAddress, WriteBus.
- After the last word of a frame is written, pulses done. done drives the output stage's start, which then reads the scratchpad and copies it to output memory.

---
 rtl/sp_result_writer.sv | 84 ++++++++
 tb/tb_sp_result_writer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sp_result_writer.sv
// sp_result_writer: accepts a valid/ready result stream, writes each word to the
// scratchpad write port and pulses done once the frame's final write has landed.
module sp_result_writer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int NUM_WORDS = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              SP_WriteEnable,
  output logic [ADDR_W-1:0] SP_WriteAddress,
  output logic [DATA_W-1:0] SP_WriteBus,
  output logic              busy,
  output logic              done,
  output logic              len_error
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] base_q, count_q, addr_q, addr_d;
  logic [DATA_W-1:0] data_q;
  logic              we_q, busy_q, done_q, err_q;
  logic              beat, at_end;
  assign in_ready        = state_q == RUN;
  assign beat            = in_valid && in_ready;
  assign at_end          = count_q == ADDR_W'(NUM_WORDS - 1);
  assign addr_d          = base_q + count_q;
  assign SP_WriteEnable  = we_q;
  assign SP_WriteAddress = addr_q;
  assign SP_WriteBus     = data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign len_error       = err_q;
  // A frame ends on whichever comes first: the last slot or in_last; any disagreement is a length error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          base_q  <= base_addr;
          count_q <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        RUN: if (beat) begin
          we_q    <= 1'b1;
          addr_q  <= addr_d;
          data_q  <= in_data;
          count_q <= count_q + 1'b1;
          if (at_end || in_last) begin
            err_q   <= err_q | (at_end ^ in_last);
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sp_result_writer.sv
// tb_sp_result_writer: directed and randomized frames against a frame-level model.
module tb_sp_result_writer;
  localparam int NW = 4;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready, SP_WriteEnable, busy, done, len_error;
  logic [11:0] SP_WriteAddress;
  logic [15:0] SP_WriteBus;
  int checks = 0;
  int errors = 0;

  sp_result_writer #(.DATA_W(16), .ADDR_W(12), .NUM_WORDS(NW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .SP_WriteEnable(SP_WriteEnable), .SP_WriteAddress(SP_WriteAddress),
    .SP_WriteBus(SP_WriteBus), .busy(busy), .done(done), .len_error(len_error)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // last_idx < 0 means in_last is never raised; gap_mode 0 none, 1 two idles before word 2, 2 random
  task automatic frame(input logic [11:0] base, input int last_idx, input int gap_mode,
                       input logic [15:0] dbase, input bit poke_start);
    int fin;
    int g;
    bit lst;
    bit exp_err;
    logic [15:0] d;
    fin = NW - 1;
    start = 1'b1;
    base_addr = base;
    step();
    start = 1'b0;
    chk("start_ready", in_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_err_clear", len_error, 0);
    for (int i = 0; i < NW; i++) begin
      g = gap_mode == 1 ? (i == 2 ? 2 : 0) : gap_mode == 2 ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        in_data = 16'($urandom);
        in_last = 1'($urandom);
        start = poke_start;
        base_addr = 12'($urandom);
        step();
        chk("gap_we", SP_WriteEnable, 0);
        chk("gap_ready", in_ready, 1);
        if (i > 0) chk("gap_addr_hold", SP_WriteAddress, 12'(base + 12'(i - 1)));
      end
      lst = i == last_idx;
      d = dbase + 16'(i);
      in_valid = 1'b1;
      in_data = d;
      in_last = lst;
      start = poke_start;
      base_addr = 12'($urandom);
      step();
      chk("write_we", SP_WriteEnable, 1);
      chk("write_addr", SP_WriteAddress, 12'(base + 12'(i)));
      chk("write_data", SP_WriteBus, d);
      chk("write_no_done", done, 0);
      if (lst || i == NW - 1) begin
        fin = i;
        break;
      end
    end
    exp_err = !(fin == NW - 1 && last_idx == fin);
    chk("flush_ready", in_ready, 0);
    chk("flush_busy", busy, 1);
    step();
    chk("done_pulse", done, 1);
    chk("done_we", SP_WriteEnable, 0);
    chk("done_busy", busy, 1);
    chk("done_len_error", len_error, exp_err);
    step();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", in_ready, 0);
    chk("idle_we", SP_WriteEnable, 0);
    chk("idle_len_error", len_error, exp_err);
    in_valid = 1'b0;
    in_last = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int li;
    #1;
    chk("rst_we", SP_WriteEnable, 0);
    chk("rst_addr", SP_WriteAddress, 0);
    chk("rst_bus", SP_WriteBus, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_err", len_error, 0);
    #11 reset_n = 1'b1;
    step();
    chk("idle_after_rst", busy, 0);
    frame(12'h010, 3, 0, 16'hA000, 1'b0);
    frame(12'h010, 3, 1, 16'hA000, 1'b0);
    frame(12'hFFE, 3, 0, 16'hB000, 1'b0);
    frame(12'h020, 1, 0, 16'hC000, 1'b0);
    frame(12'h030, 3, 2, 16'hC100, 1'b0);
    frame(12'h040, -1, 0, 16'hD000, 1'b1);
    // reset in the middle of the third write cycle
    start = 1'b1;
    base_addr = 12'h200;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 16'hE000 + 16'(i);
      in_last = 1'b0;
      step();
    end
    chk("pre_rst_we", SP_WriteEnable, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_we", SP_WriteEnable, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", in_ready, 0);
    chk("async_done", done, 0);
    in_valid = 1'b0;
    step();
    step();
    chk("held_rst_done", done, 0);
    #3 reset_n = 1'b1;
    frame(12'h100, 3, 0, 16'h5500, 1'b0);
    repeat (16) begin
      li = int'($urandom_range(0, NW));
      frame(12'($urandom), li == NW ? -1 : li, 2, 16'($urandom), 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
